// File: rtl/alu_ctrl_decode_stage.sv
// alu_ctrl_decode_stage
//   ID->EX stage for RV32I ALU-class instructions (OP, OP-IMM, LUI, AUIPC).
//   It decodes the instruction into the 6-bit ALU control word, operand selects
//   and immediate, then registers the result into the ID/EX pipeline register.
//   The register uses valid/ready back-pressure and can be flushed.
//   Opcodes that are not ALU-class still travel down the pipe as valid entries
//   with alu_class=0, so the other decoders keep seeing them.
//
// Ports
//   clk, rst_n              clock (rising edge) and async active-low reset
//   id_valid/id_ready       input handshake (id_ready is combinational)
//   id_instr, id_pc         instruction word and its PC
//   flush                   kill the ID/EX contents and drop the input
//   ex_valid/ex_ready       output handshake
//   ex_aluc                 {shift_type[1:0], op_sel, mux_sel[2:0]}
//   ex_imm                  immediate (I-type sign-extended, shamt, or U-type)
//   ex_src_b_imm/src_a_pc   operand selects
//   ex_rs1/ex_rs2/ex_rd     register indices (raw instruction fields)
//   ex_reg_we               rd write enable
//   ex_setlt                00 none, 01 SLT, 10 SLTU
//   ex_alu_class/ex_illegal decode classification
//   ex_pc                   registered PC
module alu_ctrl_decode_stage #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [5:0]      ex_aluc,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_src_b_imm,
  output logic            ex_src_a_pc,
  output logic [AW-1:0]   ex_rs1,
  output logic [AW-1:0]   ex_rs2,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_reg_we,
  output logic [1:0]      ex_setlt,
  output logic            ex_alu_class,
  output logic            ex_illegal,
  output logic [XLEN-1:0] ex_pc
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [5:0] ALUC_ADD = 6'b000000;
  localparam logic [5:0] ALUC_SUB = 6'b001000;
  localparam logic [5:0] ALUC_AND = 6'b000010;
  localparam logic [5:0] ALUC_OR  = 6'b001010;
  localparam logic [5:0] ALUC_XOR = 6'b000100;
  localparam logic [5:0] ALUC_LUI = 6'b001100;
  localparam logic [5:0] ALUC_SLL = 6'b000101;
  localparam logic [5:0] ALUC_SRL = 6'b001101;
  localparam logic [5:0] ALUC_SRA = 6'b011101;

  typedef struct packed {
    logic [5:0]      aluc;
    logic [XLEN-1:0] imm;
    logic            src_b_imm;
    logic            src_a_pc;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic            reg_we;
    logic [1:0]      setlt;
    logic            alu_class;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } ex_t;

  // ---------------- decode ----------------
  logic [6:0]         opc, f7;
  logic [2:0]         f3;
  logic signed [11:0] i12;
  logic signed [31:0] u32;
  logic [4:0]         shamt;
  logic               alt, legal;
  logic [5:0]         op_aluc;
  logic [1:0]         op_setlt;
  ex_t                dec_d;

  assign opc   = id_instr[6:0];
  assign f3    = id_instr[14:12];
  assign f7    = id_instr[31:25];
  assign i12   = id_instr[31:20];
  assign u32   = {id_instr[31:12], 12'b0};
  assign shamt = id_instr[24:20];

  // Shared funct3 -> ALU word table. alt selects SUB/SRA; the compare ops
  // reuse the SUB word and mark the flavour in setlt.
  always_comb begin
    op_aluc  = ALUC_ADD;
    op_setlt = 2'b00;
    case (f3)
      3'b000: op_aluc = alt ? ALUC_SUB : ALUC_ADD;
      3'b001: op_aluc = ALUC_SLL;
      3'b010: begin op_aluc = ALUC_SUB; op_setlt = 2'b01; end
      3'b011: begin op_aluc = ALUC_SUB; op_setlt = 2'b10; end
      3'b100: op_aluc = ALUC_XOR;
      3'b101: op_aluc = alt ? ALUC_SRA : ALUC_SRL;
      3'b110: op_aluc = ALUC_OR;
      default: op_aluc = ALUC_AND;
    endcase
  end

  always_comb begin
    alt   = 1'b0;
    legal = 1'b1;
    dec_d = '0;
    dec_d.rs1 = AW'(id_instr[19:15]);
    dec_d.rs2 = AW'(id_instr[24:20]);
    dec_d.rd  = AW'(id_instr[11:7]);
    dec_d.pc  = id_pc;
    case (opc)
      OPC_OP: begin
        dec_d.alu_class = 1'b1;
        alt   = f7[5];
        legal = (f7 == 7'b0000000) ||
                (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        dec_d.aluc  = op_aluc;
        dec_d.setlt = op_setlt;
      end
      OPC_OPIMM: begin
        dec_d.alu_class = 1'b1;
        // Only SRAI has an alternate form; ADDI with imm[10]=1 is still ADD.
        alt = (f3 == 3'b101) && f7[5];
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        dec_d.aluc      = op_aluc;
        dec_d.setlt     = op_setlt;
        dec_d.src_b_imm = 1'b1;
        dec_d.imm       = (f3 == 3'b001 || f3 == 3'b101) ? XLEN'(shamt) : XLEN'(i12);
      end
      OPC_LUI: begin
        dec_d.alu_class = 1'b1;
        dec_d.aluc      = ALUC_LUI;
        dec_d.src_b_imm = 1'b1;
        dec_d.imm       = XLEN'(u32);
      end
      OPC_AUIPC: begin
        dec_d.alu_class = 1'b1;
        dec_d.aluc      = ALUC_ADD;
        dec_d.src_a_pc  = 1'b1;
        dec_d.src_b_imm = 1'b1;
        dec_d.imm       = XLEN'(u32);
      end
      default: ;
    endcase
    if (!legal) begin
      // Illegal encodings keep their indices/PC for the trap logic but
      // carry no ALU work.
      dec_d.illegal   = 1'b1;
      dec_d.aluc      = '0;
      dec_d.setlt     = '0;
      dec_d.imm       = '0;
      dec_d.src_b_imm = 1'b0;
      dec_d.src_a_pc  = 1'b0;
    end
    dec_d.reg_we = dec_d.alu_class && legal && (dec_d.rd != '0);
  end

  // ---------------- ID/EX register ----------------
  ex_t  ex_q;
  logic valid_q;
  logic load;

  // During a flush the stage is always "ready", but whatever is offered is dropped.
  assign id_ready = flush | ex_ready | ~valid_q;
  assign load     = id_valid & id_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      ex_q    <= dec_d;
    end else if (ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_aluc      = ex_q.aluc;
  assign ex_imm       = ex_q.imm;
  assign ex_src_b_imm = ex_q.src_b_imm;
  assign ex_src_a_pc  = ex_q.src_a_pc;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_we    = ex_q.reg_we;
  assign ex_setlt     = ex_q.setlt;
  assign ex_alu_class = ex_q.alu_class;
  assign ex_illegal   = ex_q.illegal;
  assign ex_pc        = ex_q.pc;

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
module tb_alu_ctrl_decode_stage;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [5:0]  aluc;
    logic [31:0] imm;
    logic        sb, sa;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [1:0]  slt;
    logic        cls, ill;
    logic [31:0] pc;
  } exp_t;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            id_valid = 1'b0, id_ready, flush = 1'b0, ex_ready = 1'b0;
  logic [31:0]     id_instr = '0;
  logic [XLEN-1:0] id_pc = '0;
  logic            ex_valid, ex_src_b_imm, ex_src_a_pc, ex_reg_we, ex_alu_class, ex_illegal;
  logic [5:0]      ex_aluc;
  logic [XLEN-1:0] ex_imm, ex_pc;
  logic [AW-1:0]   ex_rs1, ex_rs2, ex_rd;
  logic [1:0]      ex_setlt;

  int checks = 0, failures = 0, npop = 0;
  exp_t q[$];

  alu_ctrl_decode_stage #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_aluc(ex_aluc), .ex_imm(ex_imm),
    .ex_src_b_imm(ex_src_b_imm), .ex_src_a_pc(ex_src_a_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ex_setlt(ex_setlt), .ex_alu_class(ex_alu_class), .ex_illegal(ex_illegal),
    .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  function automatic exp_t actual();
    exp_t a;
    a = '{ex_aluc, ex_imm, ex_src_b_imm, ex_src_a_pc, ex_rs1, ex_rs2, ex_rd,
          ex_reg_we, ex_setlt, ex_alu_class, ex_illegal, ex_pc};
    return a;
  endfunction

  function automatic exp_t mk(logic [5:0] aluc, logic [31:0] imm, logic sb, logic sa,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic we,
                              logic [1:0] slt, logic cls, logic ill, logic [31:0] pc);
    exp_t e;
    e = '{aluc, imm, sb, sa, rs1, rs2, rd, we, slt, cls, ill, pc};
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Monitor: a killed entry leaves the queue unchecked; a consumed entry is compared.
  always @(negedge clk) begin
    if (rst_n && ex_valid) begin
      if (flush) begin
        if (q.size() > 0) void'(q.pop_front());
      end else if (ex_ready) begin
        exp_t e, a;
        a = actual();
        checks++;
        npop++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL out%0d: unexpected output aluc=%b pc=%h", npop, a.aluc, a.pc);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL out%0d: got aluc=%b imm=%h sb=%b sa=%b rs=%0d,%0d rd=%0d we=%b slt=%b cls=%b ill=%b pc=%h required aluc=%b imm=%h sb=%b sa=%b rs=%0d,%0d rd=%0d we=%b slt=%b cls=%b ill=%b pc=%h",
                     npop, a.aluc, a.imm, a.sb, a.sa, a.rs1, a.rs2, a.rd, a.we, a.slt, a.cls, a.ill, a.pc,
                     e.aluc, e.imm, e.sb, e.sa, e.rs1, e.rs2, e.rd, e.we, e.slt, e.cls, e.ill, e.pc);
          end
        end
      end
    end
  end

  // Present one instruction; push its expectation when the stage accepts it.
  // Called and returns at posedge+1.
  task automatic issue(logic [31:0] instr, logic [31:0] pc, exp_t e);
    bit done = 0;
    id_valid = 1'b1; id_instr = instr; id_pc = pc;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (id_ready) begin q.push_back(e); done = 1; end
      @(posedge clk); #1;
    end
    id_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept: instr %h not accepted within 50 cycles", instr);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Directed vectors with hand-decoded expectations.
  localparam int NV = 11;
  logic [31:0] vi [NV] = '{32'h002081B3, 32'h402081B3, 32'h40335293, 32'h123450B7,
                           32'h022081B3, 32'h00208033, 32'h00001297, 32'h0020B233,
                           32'hFFF00093, 32'h40109093, 32'h0000A103};
  exp_t ve [NV];

  initial begin
    ve[0]  = mk(6'b000000, 32'h0,        0, 0, 1, 2,    3, 1, 2'b00, 1, 0, 32'h1000); // ADD
    ve[1]  = mk(6'b001000, 32'h0,        0, 0, 1, 2,    3, 1, 2'b00, 1, 0, 32'h1004); // SUB
    ve[2]  = mk(6'b011101, 32'h3,        1, 0, 6, 3,    5, 1, 2'b00, 1, 0, 32'h1008); // SRAI
    ve[3]  = mk(6'b001100, 32'h12345000, 1, 0, 8, 3,    1, 1, 2'b00, 1, 0, 32'h100C); // LUI
    ve[4]  = mk(6'b000000, 32'h0,        0, 0, 1, 2,    3, 0, 2'b00, 1, 1, 32'h1010); // bad f7
    ve[5]  = mk(6'b000000, 32'h0,        0, 0, 1, 2,    0, 0, 2'b00, 1, 0, 32'h1014); // ADD x0
    ve[6]  = mk(6'b000000, 32'h00001000, 1, 1, 0, 0,    5, 1, 2'b00, 1, 0, 32'h1018); // AUIPC
    ve[7]  = mk(6'b001000, 32'h0,        0, 0, 1, 2,    4, 1, 2'b10, 1, 0, 32'h101C); // SLTU
    ve[8]  = mk(6'b000000, 32'hFFFFFFFF, 1, 0, 0, 5'h1F, 1, 1, 2'b00, 1, 0, 32'h1020); // ADDI -1
    ve[9]  = mk(6'b000000, 32'h0,        0, 0, 1, 1,    1, 0, 2'b00, 1, 1, 32'h1024); // bad SLLI
    ve[10] = mk(6'b000000, 32'h0,        0, 0, 1, 0,    2, 0, 2'b00, 0, 0, 32'h1028); // LW
  end

  initial begin
    exp_t e_add, e_sub, e_xori;
    e_add  = mk(6'b000000, 32'h0,   0, 0, 1, 2,     3, 1, 2'b00, 1, 0, 32'h2000);
    e_sub  = mk(6'b001000, 32'h0,   0, 0, 1, 2,     3, 1, 2'b00, 1, 0, 32'h2004);
    e_xori = mk(6'b000100, 32'h7FF, 1, 0, 1, 5'h1F, 2, 1, 2'b00, 1, 0, 32'h3004);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex", {31'b0, ex_valid, actual()} , 64'h0);
    chk("reset_id_ready", 64'(id_ready), 64'h1);
    step();
    rst_n = 1'b1;
    ex_ready = 1'b1;
    step();

    // Back-to-back directed vectors
    for (int i = 0; i < NV; i++) issue(vi[i], 32'h1000 + 32'(i * 4), ve[i]);
    repeat (3) step();

    // XORI with a wide positive immediate
    issue(32'h7FF0C113, 32'h3004, e_xori);
    repeat (2) step();

    // Back-pressure: ADD stalls in EX while SUB waits
    ex_ready = 1'b0;
    issue(32'h002081B3, 32'h2000, e_add);
    id_valid = 1'b1; id_instr = 32'h402081B3; id_pc = 32'h2004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_id_ready", 64'(id_ready), 64'h0);
      chk("stall_hold", {31'b0, ex_valid, actual()}, {31'b0, 1'b1, e_add});
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    issue(32'h402081B3, 32'h2004, e_sub);
    repeat (2) step();

    // Flush while holding a valid entry and offering a new one
    ex_ready = 1'b0;
    issue(32'h002081B3, 32'h3000, e_add);
    id_valid = 1'b1; id_instr = 32'h7FF0C113; id_pc = 32'h3004; flush = 1'b1;
    @(negedge clk);
    chk("flush_id_ready", 64'(id_ready), 64'h1);
    @(posedge clk); #1;
    flush = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    chk("flush_ex_valid", 64'(ex_valid), 64'h0);
    @(posedge clk); #1;
    ex_ready = 1'b1;
    repeat (2) step();
    chk("flush_no_capture", 64'(ex_valid), 64'h0);

    // Asynchronous reset in the middle of a stall
    ex_ready = 1'b0;
    issue(32'h402081B3, 32'h4000, e_sub);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ex", {31'b0, ex_valid, actual()}, 64'h0);
    chk("async_reset_id_ready", 64'(id_ready), 64'h1);
    q.delete();
    step();
    rst_n = 1'b1;
    ex_ready = 1'b1;
    repeat (3) step();

    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
